pattern_sweep_gen: RTL and testbench

//  Synthesizable, parametrised exhaustive-stimulus generator for self-checking benches and on-chip BIST.

---
 rtl/pattern_sweep_pkg.sv | 24 ++
 rtl/pattern_sweep_gen_if.sv | 26 ++
 rtl/pattern_lfsr.sv | 36 +++
 rtl/pattern_sweep_gen.sv | 144 ++++++++++++++
 tb/tb_pattern_sweep_gen.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_sweep_pkg.sv
// Shared types and helpers for the pattern sweep generator.
// Mode and FSM encodings plus the Gray-code helper used by the vector mux.
package pattern_sweep_pkg;

    typedef enum logic [1:0] {
        MODE_BIN  = 2'd0,
        MODE_GRAY = 2'd1,
        MODE_WALK = 2'd2,
        MODE_LFSR = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    localparam int unsigned MaxWidth = 16;

    function automatic logic [MaxWidth-1:0] gray_of(input logic [MaxWidth-1:0] idx);
        return idx ^ (idx >> 1);
    endfunction

endpackage

// File: rtl/pattern_sweep_gen_if.sv
// Control/stimulus bundle between a sweep controller (master) and the generator (slave).
interface pattern_sweep_gen_if #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned HOLD_W = 8
);
    logic              start;
    logic              stop;
    logic [1:0]        mode;
    logic              loop;
    logic [HOLD_W-1:0] hold;
    logic [WIDTH-1:0]  vec;
    logic              vec_valid;
    logic [WIDTH-1:0]  idx;
    logic              busy;
    logic              done;

    modport master (
        output start, stop, mode, loop, hold,
        input  vec, vec_valid, idx, busy, done
    );

    modport slave (
        input  start, stop, mode, loop, hold,
        output vec, vec_valid, idx, busy, done
    );
endinterface

// File: rtl/pattern_lfsr.sv
// Fibonacci-style shift-left LFSR with synchronous load of the seed and single-step advance.
// A zero seed would lock up, so it is replaced by 1.
module pattern_lfsr #(
    parameter int unsigned      WIDTH = 3,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(3'b110),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] q_o
);
    localparam logic [WIDTH-1:0] Start = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = Start;
        end else if (step_i) begin
            q_d = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= Start;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;
endmodule

// File: rtl/pattern_sweep_gen.sv
// Exhaustive stimulus sweep generator: binary, Gray, walking-one and (with PATTERN_LFSR_EN) LFSR
// orderings, each vector held hold+1 cycles, with start/stop/done handshake.
module pattern_sweep_gen
    import pattern_sweep_pkg::*;
#(
    parameter int unsigned      WIDTH  = 3,
    parameter int unsigned      HOLD_W = 8,
    parameter logic [WIDTH-1:0] TAPS   = WIDTH'(3'b110),
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(1)
) (
    input logic               clk,
    input logic               rst,
    pattern_sweep_gen_if.slave bus_io
);
    state_e            state_q, state_d;
    mode_e             mode_q, mode_d, mode_in;
    logic              loop_q, loop_d;
    logic [HOLD_W-1:0] hold_q, hold_d, cnt_q, cnt_d;
    logic [WIDTH-1:0]  idx_q, idx_d, vec_q, vec_d;
    logic [WIDTH-1:0]  last_idx, vec_out;
    logic              lfsr_load, lfsr_step;

    function automatic logic [WIDTH-1:0] pat_of(input mode_e m, input logic [WIDTH-1:0] i);
        case (m)
            MODE_GRAY: pat_of = WIDTH'(gray_of(MaxWidth'(i)));
            MODE_WALK: pat_of = WIDTH'(1) << i;
            default:   pat_of = i;
        endcase
    endfunction

    always_comb begin
        mode_in = mode_e'(bus_io.mode);
`ifndef PATTERN_LFSR_EN
        if (mode_in == MODE_LFSR) mode_in = MODE_BIN;
`endif
    end

    always_comb begin
        case (mode_q)
            MODE_WALK: last_idx = WIDTH'(WIDTH - 1);
            MODE_LFSR: last_idx = WIDTH'(2 ** WIDTH - 2);
            default:   last_idx = {WIDTH{1'b1}};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        loop_d    = loop_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        vec_d     = vec_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus_io.start && !bus_io.stop) begin
                    state_d   = S_RUN;
                    mode_d    = mode_in;
                    loop_d    = bus_io.loop;
                    hold_d    = bus_io.hold;
                    cnt_d     = bus_io.hold;
                    idx_d     = '0;
                    vec_d     = pat_of(mode_in, '0);
                    lfsr_load = 1'b1;
                end
            end
            S_RUN: begin
                if (bus_io.stop) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end else if (idx_q == last_idx) begin
                    // Looping restarts in the same cycle so the stream has no gap.
                    if (loop_q) begin
                        idx_d     = '0;
                        cnt_d     = hold_q;
                        vec_d     = pat_of(mode_q, '0);
                        lfsr_load = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    idx_d     = idx_q + WIDTH'(1);
                    cnt_d     = hold_q;
                    vec_d     = pat_of(mode_q, idx_q + WIDTH'(1));
                    lfsr_step = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_BIN;
            loop_q  <= 1'b0;
            hold_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            loop_q  <= loop_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
        end
    end

`ifdef PATTERN_LFSR_EN
    logic [WIDTH-1:0] lfsr_q;

    pattern_lfsr #(
        .WIDTH(WIDTH),
        .TAPS (TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load_i(lfsr_load),
        .step_i(lfsr_step),
        .q_o   (lfsr_q)
    );

    assign vec_out = (mode_q == MODE_LFSR) ? lfsr_q : vec_q;
`else
    logic unused_lfsr;
    assign unused_lfsr = ^{TAPS, SEED, lfsr_load, lfsr_step};
    assign vec_out     = vec_q;
`endif

    assign bus_io.vec       = vec_out;
    assign bus_io.idx       = idx_q;
    assign bus_io.vec_valid = (state_q == S_RUN);
    assign bus_io.busy      = (state_q == S_RUN);
    assign bus_io.done      = (state_q == S_DONE);
endmodule

// File: tb/tb_pattern_sweep_gen.sv
// Self-checking bench for pattern_sweep_gen: expected sweeps come from a list-based model.
module tb_pattern_sweep_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pattern_sweep_gen_if #(.WIDTH(3), .HOLD_W(8)) bus3 ();
    pattern_sweep_gen_if #(.WIDTH(4), .HOLD_W(8)) bus4 ();

    pattern_sweep_gen #(.WIDTH(3), .HOLD_W(8), .TAPS(3'b110), .SEED(3'd1)) u_dut3 (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus3.slave)
    );

    pattern_sweep_gen #(.WIDTH(4), .HOLD_W(8), .TAPS(4'b1100), .SEED(4'd1)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus4.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    // Expected 3-bit sweep for a requested mode, straight from the ordering rules.
    function automatic void build_exp(input int m);
        int v;
        exp_q.delete();
        case (m)
            1: for (int i = 0; i < 8; i++) exp_q.push_back(i ^ (i >> 1));
            2: for (int i = 0; i < 3; i++) exp_q.push_back(1 << i);
            3: begin
`ifdef PATTERN_LFSR_EN
                v = 1;
                for (int i = 0; i < 7; i++) begin
                    exp_q.push_back(v);
                    v = ((v << 1) & 7) | ($countones(v & 6) % 2);
                end
`else
                for (int i = 0; i < 8; i++) exp_q.push_back(i);
`endif
            end
            default: for (int i = 0; i < 8; i++) exp_q.push_back(i);
        endcase
    endfunction

    task automatic idle_inputs();
        bus3.start = 0; bus3.stop = 0; bus3.mode = 0; bus3.loop = 0; bus3.hold = 0;
        bus4.start = 0; bus4.stop = 0; bus4.mode = 0; bus4.loop = 0; bus4.hold = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus3.vec, bus3.idx, bus3.vec_valid, bus3.busy, bus3.done} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset3: got %b expected %b",
                     {bus3.vec, bus3.idx, bus3.vec_valid, bus3.busy, bus3.done}, 9'b0);
        end
        n_checks++;
        if ({bus4.vec, bus4.idx, bus4.vec_valid, bus4.busy, bus4.done} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset4: got %b expected %b",
                     {bus4.vec, bus4.idx, bus4.vec_valid, bus4.busy, bus4.done}, 11'b0);
        end
        rst = 0;
    endtask

    // Full non-looping sweep on the 3-bit DUT; inputs are scrambled after start to prove latching.
    task automatic test_sweep(input int m, input int h);
        int last;
        build_exp(m);
        last = exp_q[exp_q.size() - 1];
        @(negedge clk);
        bus3.start = 1; bus3.mode = 2'(m); bus3.hold = 8'(h); bus3.loop = 0;
        @(negedge clk);
        bus3.start = 0; bus3.mode = 2'($urandom); bus3.hold = 8'($urandom_range(0, 5));
        bus3.loop = 1;
        for (int j = 0; j < exp_q.size(); j++) begin
            for (int c = 0; c <= h; c++) begin
                n_checks++;
                if ({bus3.vec, bus3.idx, bus3.vec_valid, bus3.busy, bus3.done} !==
                    {3'(exp_q[j]), 3'(j), 3'b110}) begin
                    n_fail++;
                    $display("FAIL sweep m=%0d h=%0d step=%0d cyc=%0d: got %b expected %b",
                             m, h, j, c,
                             {bus3.vec, bus3.idx, bus3.vec_valid, bus3.busy, bus3.done},
                             {3'(exp_q[j]), 3'(j), 3'b110});
                end
                bus3.start = (j == 1 && c == 0);
                @(negedge clk);
            end
        end
        n_checks++;
        if ({bus3.vec, bus3.vec_valid, bus3.busy, bus3.done} !== {3'(last), 3'b001}) begin
            n_fail++;
            $display("FAIL done m=%0d: got %b expected %b", m,
                     {bus3.vec, bus3.vec_valid, bus3.busy, bus3.done}, {3'(last), 3'b001});
        end
        bus3.start = 1;
        @(negedge clk);
        n_checks++;
        if ({bus3.vec_valid, bus3.busy, bus3.done} !== 3'b000) begin
            n_fail++;
            $display("FAIL post_done m=%0d: got %b expected %b", m,
                     {bus3.vec_valid, bus3.busy, bus3.done}, 3'b000);
        end
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (bus3.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_done m=%0d: busy got %b expected 0", m, bus3.busy);
        end
    endtask

    task automatic test_walk4();
        @(negedge clk);
        bus4.start = 1; bus4.mode = 2; bus4.hold = 2;
        @(negedge clk);
        bus4.start = 0; bus4.hold = 0; bus4.mode = 0;
        for (int j = 0; j < 4; j++) begin
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if ({bus4.vec, bus4.idx, bus4.vec_valid, bus4.busy, bus4.done} !==
                    {4'(1 << j), 4'(j), 3'b110}) begin
                    n_fail++;
                    $display("FAIL walk4 step=%0d cyc=%0d: got %b expected %b", j, c,
                             {bus4.vec, bus4.idx, bus4.vec_valid, bus4.busy, bus4.done},
                             {4'(1 << j), 4'(j), 3'b110});
                end
                @(negedge clk);
            end
        end
        n_checks++;
        if ({bus4.vec, bus4.vec_valid, bus4.busy, bus4.done} !== {4'b1000, 3'b001}) begin
            n_fail++;
            $display("FAIL walk4_done: got %b expected %b",
                     {bus4.vec, bus4.vec_valid, bus4.busy, bus4.done}, {4'b1000, 3'b001});
        end
        @(negedge clk);
    endtask

    task automatic test_loop_stop();
        @(negedge clk);
        bus3.start = 1; bus3.mode = 0; bus3.hold = 0; bus3.loop = 1;
        @(negedge clk);
        bus3.start = 0; bus3.loop = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            n_checks++;
            if ({bus3.vec, bus3.idx, bus3.vec_valid, bus3.busy, bus3.done} !==
                {3'(cyc % 8), 3'(cyc % 8), 3'b110}) begin
                n_fail++;
                $display("FAIL loop cyc=%0d: got %b expected %b", cyc,
                         {bus3.vec, bus3.idx, bus3.vec_valid, bus3.busy, bus3.done},
                         {3'(cyc % 8), 3'(cyc % 8), 3'b110});
            end
            bus3.stop = (cyc == 19);
            @(negedge clk);
        end
        bus3.stop = 0;
        n_checks++;
        if ({bus3.idx, bus3.vec_valid, bus3.busy, bus3.done} !== 6'b0) begin
            n_fail++;
            $display("FAIL stop: got %b expected %b",
                     {bus3.idx, bus3.vec_valid, bus3.busy, bus3.done}, 6'b0);
        end
        @(negedge clk);
        n_checks++;
        if ({bus3.busy, bus3.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL stop_no_done: got %b expected 00", {bus3.busy, bus3.done});
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus3.start = 1; bus3.mode = 0; bus3.hold = 0;
        @(negedge clk);
        bus3.start = 0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus3.vec !== 3'd5) begin
            n_fail++;
            $display("FAIL pre_reset vec: got %0d expected 5", bus3.vec);
        end
        rst = 1;
        @(negedge clk);
        rst = 0;
        n_checks++;
        if ({bus3.vec, bus3.idx, bus3.vec_valid, bus3.busy, bus3.done} !== 9'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got %b expected %b",
                     {bus3.vec, bus3.idx, bus3.vec_valid, bus3.busy, bus3.done}, 9'b0);
        end
        @(negedge clk);
        bus3.start = 1;
        @(negedge clk);
        bus3.start = 0;
        n_checks++;
        if ({bus3.vec, bus3.idx, bus3.vec_valid, bus3.busy, bus3.done} !== 9'b000_000_110) begin
            n_fail++;
            $display("FAIL restart: got %b expected %b",
                     {bus3.vec, bus3.idx, bus3.vec_valid, bus3.busy, bus3.done}, 9'b000_000_110);
        end
        bus3.stop = 1;
        @(negedge clk);
        bus3.stop = 0;
    endtask

    task automatic test_start_with_stop();
        @(negedge clk);
        bus3.start = 1; bus3.stop = 1;
        @(negedge clk);
        idle_inputs();
        n_checks++;
        if ({bus3.vec_valid, bus3.busy, bus3.done} !== 3'b000) begin
            n_fail++;
            $display("FAIL start_stop_idle: got %b expected 000",
                     {bus3.vec_valid, bus3.busy, bus3.done});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            test_sweep(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_sweep(0, 0);
        test_sweep(1, 0);
        test_sweep(2, 1);
        test_sweep(3, 0);
        test_walk4();
        test_loop_stop();
        test_reset_mid();
        test_start_with_stop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
